// File: rtl/seq_cmd_driver_if.sv
// rtl/seq_cmd_driver_if.sv - command, response and unit signals of seq_cmd_driver
interface seq_cmd_driver_if;
  // command port
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x;
  logic [7:0] cmd_len;
  // unit port
  logic [1:0] on;
  logic       start;
  logic [7:0] x;
  logic [1:0] regime;
  logic       active;
  logic [7:0] y;
  logic [2:0] s;
  logic       b;
  // response port
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic [2:0] rsp_s;
  logic       rsp_b;
  logic [7:0] rsp_cycles;
  logic [7:0] rsp_active;
  logic       rsp_err;
  logic       busy;

  // driver side
  modport master (
    input  cmd_valid, cmd_op, cmd_x, cmd_len,
    output cmd_ready,
    output on, start, x,
    input  regime, active, y, s, b,
    output rsp_valid, rsp_y, rsp_s, rsp_b, rsp_cycles, rsp_active, rsp_err, busy,
    input  rsp_ready
  );

  // sequencer and unit side
  modport slave (
    output cmd_valid, cmd_op, cmd_x, cmd_len,
    input  cmd_ready,
    input  on, start, x,
    output regime, active, y, s, b,
    input  rsp_valid, rsp_y, rsp_s, rsp_b, rsp_cycles, rsp_active, rsp_err, busy,
    output rsp_ready
  );
endinterface

// File: rtl/seq_cmd_driver.sv
// rtl/seq_cmd_driver.sv - drives the mode-controlled unit through one command at a time
module seq_cmd_driver #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_cmd_driver_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_HOLD,
    S_RELEASE,
    S_RESPOND
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [1:0]    r_op;
  logic [7:0]    r_len;
  logic [TW-1:0] r_tmo;

  logic [1:0]    r_on;
  logic          r_start;
  logic [7:0]    r_x;
  logic          r_cmd_ready;
  logic          r_busy;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_y;
  logic [2:0]    r_rsp_s;
  logic          r_rsp_b;
  logic [7:0]    r_cycles;
  logic [7:0]    r_active;
  logic          r_err;

  logic          w_accept;
  logic          w_capture;
  logic          w_err_set;
  logic          w_tmo_hit;
  logic          w_counting;
  logic [1:0]    w_op;

  // the unit is only being driven in these states; statistics accumulate here
  assign w_counting = (r_state == S_LAUNCH) || (r_state == S_HOLD) || (r_state == S_RELEASE);
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
  // op as it will be in the next cycle, so registered outputs line up with the state
  assign w_op       = w_accept ? bus.cmd_op : r_op;

  // next-state and transition strobes
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_accept = 1'b1;
          if (bus.cmd_op == 2'd0) begin
            w_next    = S_RESPOND;
            w_capture = 1'b1;
          end else begin
            w_next = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (bus.regime == r_op) begin
          if (r_op == 2'd3 || r_len == 8'd0) begin
            w_next = S_RELEASE;
          end else begin
            w_next = S_HOLD;
          end
        end else if (w_tmo_hit) begin
          w_next    = S_RESPOND;
          w_err_set = 1'b1;
          w_capture = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_len == 8'd1) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (bus.regime == 2'd0) begin
          w_next    = S_RESPOND;
          w_capture = 1'b1;
        end else if (w_tmo_hit) begin
          w_next    = S_RESPOND;
          w_err_set = 1'b1;
          w_capture = 1'b1;
        end
      end
      S_RESPOND: begin
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // command latch, hold-length countdown and per-state timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 2'd0;
      r_len <= 8'd0;
      r_tmo <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.cmd_op;
        r_len <= bus.cmd_len;
      end else if (r_state == S_HOLD) begin
        r_len <= r_len - 8'd1;
      end
      if (w_next != r_state) begin
        r_tmo <= '0;
      end else if (r_tmo < TW'(TIMEOUT)) begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  // unit-facing and handshake outputs, decoded from the next state so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on        <= 2'd0;
      r_start     <= 1'b0;
      r_x         <= 8'd0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_on        <= (w_next == S_LAUNCH) ? w_op : 2'd0;
      r_start     <= ((w_next == S_LAUNCH) && (w_op == 2'd1 || w_op == 2'd2)) ||
                     (w_next == S_HOLD);
      r_cmd_ready <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_rsp_valid <= (w_next == S_RESPOND);
      if (w_next == S_IDLE) begin
        r_x <= 8'd0;
      end else if (w_accept && w_next == S_LAUNCH) begin
        r_x <= bus.cmd_x;
      end
    end
  end

  // response fields: statistics counters saturate, unit outputs captured at completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= 8'd0;
      r_active <= 8'd0;
      r_err    <= 1'b0;
      r_rsp_y  <= 8'd0;
      r_rsp_s  <= 3'd0;
      r_rsp_b  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cycles <= 8'd0;
        r_active <= 8'd0;
        r_err    <= 1'b0;
      end else begin
        if (w_counting && r_cycles != 8'hFF) begin
          r_cycles <= r_cycles + 8'd1;
        end
        if (w_counting && bus.active && r_active != 8'hFF) begin
          r_active <= r_active + 8'd1;
        end
        if (w_err_set) begin
          r_err <= 1'b1;
        end
      end
      if (w_capture) begin
        r_rsp_y <= bus.y;
        r_rsp_s <= bus.s;
        r_rsp_b <= bus.b;
      end
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.on         = r_on;
  assign bus.start      = r_start;
  assign bus.x          = r_x;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_y      = r_rsp_y;
  assign bus.rsp_s      = r_rsp_s;
  assign bus.rsp_b      = r_rsp_b;
  assign bus.rsp_cycles = r_cycles;
  assign bus.rsp_active = r_active;
  assign bus.rsp_err    = r_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_seq_cmd_driver.sv
// tb/tb_seq_cmd_driver.sv - directed self-checking bench for seq_cmd_driver
module tb_seq_cmd_driver;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_start;

  seq_cmd_driver_if u_if ();

  seq_cmd_driver #(.TIMEOUT(64), .TW(7)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] xv, input logic [7:0] len);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_x     = xv;
    u_if.cmd_len   = len;
    tick();
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    u_if.rsp_ready = 1'b1;
    tick();
    u_if.rsp_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n            = 1'b0;
    u_if.cmd_valid   = 1'b0;
    u_if.cmd_op      = 2'd0;
    u_if.cmd_x       = 8'd0;
    u_if.cmd_len     = 8'd0;
    u_if.regime      = 2'd0;
    u_if.active      = 1'b0;
    u_if.y           = 8'd0;
    u_if.s           = 3'd0;
    u_if.b           = 1'b0;
    u_if.rsp_ready   = 1'b0;
    tick(2);
    check_eq("rst_on", u_if.on, 0);
    check_eq("rst_start", u_if.start, 0);
    check_eq("rst_rsp_valid", u_if.rsp_valid, 0);
    check_eq("rst_busy", u_if.busy, 0);
    check_eq("rst_cmd_ready", u_if.cmd_ready, 1);
    check_eq("rst_cycles", u_if.rsp_cycles, 0);
    rst_n = 1'b1;
    tick();

    // update: ack one cycle late, regime back to 0 two cycles after ack
    send_cmd(2'd3, 8'hA5, 8'd0);
    check_eq("upd_on_launch", u_if.on, 3);
    check_eq("upd_start_launch", u_if.start, 0);
    check_eq("upd_x", u_if.x, 8'hA5);
    check_eq("upd_cmd_ready", u_if.cmd_ready, 0);
    tick();
    u_if.regime = 2'd3;
    u_if.y = 8'h5A; u_if.s = 3'd3; u_if.b = 1'b1;
    check_eq("upd_on_launch2", u_if.on, 3);
    tick();
    check_eq("upd_on_release", u_if.on, 0);
    check_eq("upd_start_release", u_if.start, 0);
    check_eq("upd_x_release", u_if.x, 8'hA5);
    tick();
    u_if.regime = 2'd0;
    tick();
    check_eq("upd_rsp_valid", u_if.rsp_valid, 1);
    check_eq("upd_rsp_y", u_if.rsp_y, 8'h5A);
    check_eq("upd_rsp_s", u_if.rsp_s, 3);
    check_eq("upd_rsp_b", u_if.rsp_b, 1);
    check_eq("upd_rsp_err", u_if.rsp_err, 0);
    check_eq("upd_rsp_cycles", u_if.rsp_cycles, 4);
    finish_rsp();
    check_eq("upd_idle_valid", u_if.rsp_valid, 0);
    check_eq("upd_idle_ready", u_if.cmd_ready, 1);
    check_eq("upd_idle_x", u_if.x, 0);

    // count: immediate ack, hold 5 cycles, regime 0 two cycles into release
    send_cmd(2'd2, 8'h10, 8'd5);
    u_if.regime = 2'd2;
    check_eq("cnt_start_launch", u_if.start, 1);
    check_eq("cnt_on_launch", u_if.on, 2);
    tick();
    n_start = 0;
    for (int i = 0; i < 5; i++) begin
      if (u_if.start === 1'b1 && u_if.on === 2'd0) n_start++;
      tick();
    end
    check_eq("cnt_hold_cycles", n_start, 5);
    check_eq("cnt_start_low", u_if.start, 0);
    tick();
    u_if.regime = 2'd0;
    u_if.y = 8'h77; u_if.s = 3'd5; u_if.b = 1'b0;
    tick();
    check_eq("cnt_rsp_valid", u_if.rsp_valid, 1);
    check_eq("cnt_rsp_cycles", u_if.rsp_cycles, 8);
    check_eq("cnt_rsp_s", u_if.rsp_s, 5);
    check_eq("cnt_rsp_y", u_if.rsp_y, 8'h77);
    finish_rsp();

    // enumerate: active for 4 release cycles
    send_cmd(2'd1, 8'h22, 8'd3);
    u_if.regime = 2'd1;
    tick();
    tick(3);
    check_eq("enu_start_low", u_if.start, 0);
    u_if.active = 1'b1;
    tick(4);
    u_if.active = 1'b0;
    u_if.regime = 2'd0;
    tick();
    check_eq("enu_rsp_valid", u_if.rsp_valid, 1);
    check_eq("enu_rsp_active", u_if.rsp_active, 4);
    check_eq("enu_rsp_cycles", u_if.rsp_cycles, 9);
    check_eq("enu_rsp_err", u_if.rsp_err, 0);
    finish_rsp();

    // timeout: regime never acknowledges
    send_cmd(2'd2, 8'h33, 8'd3);
    tick(63);
    check_eq("tmo_on_last", u_if.on, 2);
    check_eq("tmo_start_last", u_if.start, 1);
    check_eq("tmo_valid_last", u_if.rsp_valid, 0);
    tick();
    check_eq("tmo_on", u_if.on, 0);
    check_eq("tmo_start", u_if.start, 0);
    check_eq("tmo_rsp_valid", u_if.rsp_valid, 1);
    check_eq("tmo_rsp_err", u_if.rsp_err, 1);
    check_eq("tmo_rsp_cycles", u_if.rsp_cycles, 64);
    finish_rsp();

    // nop with backpressure, then a command offered in the handshake cycle
    u_if.y = 8'h3C; u_if.s = 3'd6; u_if.b = 1'b1;
    send_cmd(2'd0, 8'h44, 8'd0);
    check_eq("nop_rsp_valid", u_if.rsp_valid, 1);
    check_eq("nop_rsp_cycles", u_if.rsp_cycles, 0);
    check_eq("nop_rsp_err", u_if.rsp_err, 0);
    check_eq("nop_rsp_y", u_if.rsp_y, 8'h3C);
    u_if.y = 8'hFF; u_if.s = 3'd1; u_if.b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_rsp_y", u_if.rsp_y, 8'h3C);
      check_eq("bp_rsp_valid", u_if.rsp_valid, 1);
      check_eq("bp_cmd_ready", u_if.cmd_ready, 0);
    end
    check_eq("bp_rsp_s", u_if.rsp_s, 6);
    u_if.rsp_ready = 1'b1;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = 2'd3;
    u_if.cmd_x     = 8'h11;
    u_if.cmd_len   = 8'd0;
    tick();
    u_if.rsp_ready = 1'b0;
    check_eq("hs_not_busy", u_if.busy, 0);
    check_eq("hs_cmd_ready", u_if.cmd_ready, 1);
    check_eq("hs_on", u_if.on, 0);
    tick();
    u_if.cmd_valid = 1'b0;
    check_eq("hs_accept_busy", u_if.busy, 1);
    check_eq("hs_accept_on", u_if.on, 3);
    check_eq("hs_accept_x", u_if.x, 8'h11);
    u_if.regime = 2'd3;
    tick();
    u_if.regime = 2'd0;
    tick();
    check_eq("hs_rsp_valid", u_if.rsp_valid, 1);
    finish_rsp();

    // reset during hold
    send_cmd(2'd2, 8'h55, 8'd20);
    u_if.regime = 2'd2;
    tick();
    tick(6);
    check_eq("rh_start_hold", u_if.start, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rh_on", u_if.on, 0);
    check_eq("rh_start", u_if.start, 0);
    check_eq("rh_busy", u_if.busy, 0);
    u_if.regime = 2'd0;
    tick();
    rst_n = 1'b1;
    tick(2);
    check_eq("rh_rsp_valid", u_if.rsp_valid, 0);
    check_eq("rh_cmd_ready", u_if.cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
